// File: rtl/logic_sweep_ctrl.sv
// Exhaustive truth-table sweeper for a small combinational network: steps every
// input vector, samples Y after a settle interval, and compares against EXPECTED.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; vec_out=0, busy=0
// S_SETTLE | holding vec for SETTLE_CYCLES, capturing Y on the last one
// S_DONE   | one-cycle done pulse; table_valid and pass already updated
module logic_sweep_ctrl #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'h0A
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   y_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   table_valid,
    output logic                   pass
);

    localparam int TW = 1 << N_IN;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN:0]   VEC_LAST    = (N_IN+1)'(TW - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [N_IN:0]   vec;
    logic [CW-1:0]   settle_cnt;
    logic [TW-1:0]   table_nxt;

    logic load, cnt_dec, capture, finish, cancel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        cnt_dec   = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        cancel    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    load      = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    cancel    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (settle_cnt != '0) begin
                    cnt_dec = 1'b1;
                end else begin
                    capture = 1'b1;
                    if (vec == VEC_LAST) begin
                        finish    = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Table including the bit being captured this edge, so pass is valid with done.
    always_comb begin
        table_nxt = table_out;
        table_nxt[vec[N_IN-1:0]] = y_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec         <= '0;
            settle_cnt  <= '0;
            table_out   <= '0;
            table_valid <= 1'b0;
            pass        <= 1'b0;
        end else begin
            if (load) begin
                vec         <= '0;
                settle_cnt  <= SETTLE_LOAD;
                table_out   <= '0;
                table_valid <= 1'b0;
                pass        <= 1'b0;
            end
            if (cancel) begin
                vec        <= '0;
                settle_cnt <= '0;
            end
            if (cnt_dec) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (capture) begin
                table_out <= table_nxt;
                if (finish) begin
                    vec         <= '0;
                    table_valid <= 1'b1;
                    pass        <= (table_nxt == EXPECTED);
                end else begin
                    vec        <= vec + 1'b1;
                    settle_cnt <= SETTLE_LOAD;
                end
            end
        end
    end

    assign vec_out = vec[N_IN-1:0];

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Directed bench for logic_sweep_ctrl: one instance with SETTLE_CYCLES=1 and one
// with SETTLE_CYCLES=3, each driving a model of the default gate network.
module tb_logic_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, stuck = 1'b0;
    logic       start3 = 1'b0, abort3 = 1'b0;
    logic       y1, y3;
    logic [2:0] vec1, vec3;
    logic       busy1, done1, valid1, pass1;
    logic       busy3, done3, valid3, pass3;
    logic [7:0] tab1, tab3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic net(input logic [2:0] v);
        logic a, b, c;
        {a, b, c} = v;
        return ~(a & b) & (b | c) & (a ^ c);
    endfunction

    assign y1 = stuck ? 1'b1 : net(vec1);
    assign y3 = net(vec3);

    logic_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'h0A)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y1),
        .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tab1),
        .table_valid(valid1), .pass(pass1)
    );

    logic_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(3), .EXPECTED(8'h0A)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .y_in(y3),
        .vec_out(vec3), .busy(busy3), .done(done3), .table_out(tab3),
        .table_valid(valid3), .pass(pass3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep on u_dut1; restart_at re-asserts start during that vector.
    task automatic sweep1(input int restart_at, input logic [7:0] exp_tab, input logic exp_pass);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("vec_step%0d", i), vec1, i);
            chk($sformatf("busy_step%0d", i), busy1, 1);
            chk($sformatf("done_early%0d", i), done1, 0);
            start = (i == restart_at);
            tick();
        end
        start = 1'b0;
        chk("done_pulse", done1, 1);
        chk("busy_in_done", busy1, 0);
        chk("vec_in_done", vec1, 0);
        chk("table", tab1, exp_tab);
        chk("valid", valid1, 1);
        chk("pass", pass1, exp_pass);
        tick();
        chk("done_cleared", done1, 0);
        chk("table_hold", tab1, exp_tab);
        chk("valid_hold", valid1, 1);
        chk("pass_hold", pass1, exp_pass);
    endtask

    initial begin
        logic saw_done;
        #2;
        chk("rst_vec", vec1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_table", tab1, 0);
        chk("rst_valid", valid1, 0);
        chk("rst_pass", pass1, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Nominal sweep, then one with a redundant start mid-sweep
        sweep1(-1, 8'h0A, 1'b1);
        tick();
        sweep1(2, 8'h0A, 1'b1);
        tick();

        // Stuck-at-1 network
        stuck = 1'b1;
        sweep1(-1, 8'hFF, 1'b0);
        stuck = 1'b0;
        tick();

        // Abort while vec_out==4
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort_pre_vec", vec1, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_vec", vec1, 0);
        chk("abort_valid", valid1, 0);
        chk("abort_pass", pass1, 0);
        saw_done = done1;
        repeat (12) begin
            tick();
            saw_done |= done1;
        end
        chk("abort_no_done", saw_done, 0);

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy1, 0);
        chk("sa_vec", vec1, 0);
        tick();
        chk("sa_still_idle", busy1, 0);

        // Async reset mid-sweep at vec_out==5
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("rstm_pre_vec", vec1, 5);
        rst_n = 1'b0;
        #1;
        chk("rstm_vec", vec1, 0);
        chk("rstm_busy", busy1, 0);
        chk("rstm_done", done1, 0);
        chk("rstm_table", tab1, 0);
        chk("rstm_valid", valid1, 0);
        chk("rstm_pass", pass1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        sweep1(-1, 8'h0A, 1'b1);
        tick();

        // SETTLE_CYCLES=3 instance: each vector held 3 cycles, done after 24
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("s3_vec%0d_%0d", i, j), vec3, i);
                chk($sformatf("s3_busy%0d_%0d", i, j), busy3, 1);
                chk($sformatf("s3_done%0d_%0d", i, j), done3, 0);
                tick();
            end
        end
        chk("s3_done", done3, 1);
        chk("s3_table", tab3, 8'h0A);
        chk("s3_pass", pass3, 1);
        chk("s3_valid", valid3, 1);
        tick();
        chk("s3_done_cleared", done3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/logic_sweep_ctrl.md
Name: logic_sweep_ctrl

Overview:
- Sequencer that exhaustively drives every input combination into a small combinational gate network (default 3 inputs A/B/C, 1 output Y).
- Holds each combination for a settle interval, samples Y, and assembles the network's full truth table.
- Compares the table against a parameterised expected value and reports pass/fail.
- Sits beside the gate network as its controller. A host starts sweeps with a start/busy/done handshake.

Parameters:
- N_IN, 3, number of network inputs. Table width is 2**N_IN. Legal range 1..6.
- SETTLE_CYCLES, 1, clock cycles each vector is held before Y is sampled. Must be >= 1.
- EXPECTED, 8'h0A, expected truth table (width 2**N_IN). Bit i is Y for vector value i. Default matches Y = ~(A&B) & (B|C) & (A^C).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- abort  in  1  cancel a running sweep
- y_in  in  1  network output Y
- vec_out  out  N_IN  network input vector; MSB = A, LSB = C for N_IN=3
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when a sweep completes
- table_out  out  2**N_IN  captured truth table; bit i = Y sampled with vec_out==i
- table_valid  out  1  table_out holds a complete sweep result
- pass  out  1  table_out==EXPECTED; meaningful only while table_valid=1

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. All outputs are 0: vec_out, busy, done, table_out, table_valid, pass. Internal vector and settle counters are 0.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - busy=0 and vec_out=0.
  - start=1 and abort=0 at edge k: table_out<=0, table_valid<=0, pass<=0, vec<=0, settle_cnt<=SETTLE_CYCLES-1, busy<=1, go to SETTLE.
  - start=1 and abort=1 together in IDLE: abort wins, start is ignored, and the block stays in IDLE.
- SETTLE:
  - vec_out holds vec for exactly SETTLE_CYCLES cycles.
  - Each edge with settle_cnt>0 decrements settle_cnt.
  - The edge with settle_cnt==0 captures table_out[vec]<=y_in.
  - At that edge, if vec==2**N_IN-1: go to DONE and vec_out<=0. Otherwise vec<=vec+1 and settle_cnt<=SETTLE_CYCLES-1.
- DONE (exactly one cycle):
  - done=1, busy=0, table_valid=1.
  - pass=(table_out==EXPECTED) is registered on entry, so it is valid in the same cycle as done.
  - Next edge returns to IDLE, done<=0. table_out, table_valid and pass hold until the next accepted start.
- Latency: done is high in the cycle after edge k + (2**N_IN)*SETTLE_CYCLES. Defaults: 8 cycles of sweep, then the done cycle.
- Vector counter: N_IN+1 bits wide, so 2**N_IN-1 never wraps to 0 before termination.
- start while busy or in DONE is ignored; it is not queued.
- abort=1 in SETTLE: next edge goes to IDLE with busy=0 and vec_out=0. No done pulse; table_valid and pass stay 0. The partial table_out content is undefined to the host and must not be used.
- abort in IDLE or DONE has no effect. A DONE cycle with abort still completes normally.
- y_in is sampled only at capture edges. Its value at all other times is ignored.
- Reset mid-sweep: immediate return to the reset state, no done pulse.

Test Plan:
- Default params; network model Y=~(A&B)&(B|C)&(A^C); start pulse at cycle 0 -> vec_out steps 0..7 one per cycle; done pulses once; table_out=8'h0A, pass=1, table_valid=1.
- SETTLE_CYCLES=3; the same pulse -> each vec_out value held 3 cycles; done 24 cycles after start; table_out=8'h0A.
- Faulty network (Y stuck at 1) -> table_out=8'hFF, pass=0, table_valid=1.
- abort asserted while vec_out==4 -> next cycle busy=0 and vec_out=0; no done pulse; table_valid=0.
- start re-asserted at vec_out==2 -> ignored, sweep timing unchanged. start and abort together in IDLE -> stays IDLE, busy=0.
- rst_n low for 1 cycle mid-sweep (vec_out==5) -> all outputs 0 immediately. A fresh start afterwards -> table_out=8'h0A, pass=1.
